rv_mul_seq: RTL and testbench
=============================

// Module: rv_mul_seq
// PURPOSE
//  Parametrised digit-serial multiply unit for the multicycle RISC-V core (RV32M MUL/MULH/MULHSU/MULHU).
//  Holds its own step sequencer, operand registers and 2*XLEN accumulator; the control FSM only issues
//  start, waits for done, then writes result back. Replaces the fixed 10-state byte-multiply chain in control.
// PARAMETERS
//  XLEN   32  operand/result width
//  DIGIT  8   digit width per partial product; XLEN % DIGIT == 0; ND = XLEN/DIGIT
// PORTS
//  clk     in   1     clock, rising edge
//  rst     in   1     synchronous, active-high reset
//  start   in   1     request; sampled only in IDLE
//  flush   in   1     abort current operation (synchronous)
//  funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes treated as MUL
//  op_a    in   XLEN  rs1 value, captured on accepted start
//  op_b    in   XLEN  rs2 value, captured on accepted start
//  busy    out  1     high from cycle after accepted start until DONE
//  done    out  1     one-cycle pulse, result valid
//  result  out  XLEN  product word; holds until next accepted start
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, result=0, accumulator and counters 0.
//  FSM: IDLE -(start)-> CALC -(last step)-> FIX -> DONE -> IDLE. flush in CALC/FIX -> IDLE, no done.
//  Accept edge (IDLE & start): a_mag=|op_a| if a signed, b_mag likewise; neg=sign(a)^sign(b) for signed
//   operands only; acc=0; mode, i, j = 0. MULH: a,b signed. MULHSU: a signed. MUL/MULHU: unsigned.
//  CALC, one step/cycle: acc += (a_mag digit i * b_mag digit j) << ((i+j)*DIGIT), 2*XLEN bits, wraps.
//   Order: i outer, j inner, both ascending from 0. MUL: only pairs with i+j < ND,
//   i.e. ND*(ND+1)/2 steps (10 at defaults). High modes: all ND*ND pairs (16 at defaults).
//  FIX (1 cycle): if neg, acc = -acc (two's complement over 2*XLEN).
//  DONE (1 cycle): done=1; result registered = acc[XLEN-1:0] for MUL, else acc[2*XLEN-1:XLEN].
//  Latency: done asserts S+2 cycles after the start cycle (S = step count): 12 for MUL, 18 for MULH* at defaults.
//  start while busy or in DONE: ignored. Back-to-back: start may be accepted the cycle after DONE.
//  |-2^(XLEN-1)| = 2^(XLEN-1) fits the unsigned magnitude register; no special case.
//  flush and start in same IDLE cycle: flush wins, not accepted. rst overrides everything incl. flush.
//  busy is low in IDLE only; result not updated on flushed operations.
// STRUCTURE
//  params.inc: MUL_* funct3 codes, FSM state encodings, SEQ_IDLE/CALC/FIX/DONE.
//  Sub-module rv_mul_pp: combinational DIGITxDIGIT unsigned multiply + shift by (i+j)*DIGIT into 2*XLEN.
//  Top keeps FSM, i/j counters with MUL-mode triangular skip, magnitude/sign registers, accumulator.
//  Control FSM gains one MUL_WAIT state (start on entry, leave on done) replacing MUL1..MUL10.
// TESTING
//  MUL 7 x 6 -> result 0x0000002A, busy 1 for cycles 1..12, done pulse at cycle 12.
//  MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001; MULHU same operands -> 0xFFFFFFFE at cycle 18.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
//  MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0x00010000 x 0x00010000 -> 0x00000001.
//  MULH started, flush at cycle 5 -> busy 0 next cycle, no done, result keeps old value;
//   start pulses while busy ignored; MUL 3 x 5 then -> 0x0000000F.
//  DIGIT=16 build: MUL 3 steps, done at cycle 5; MULH 4 steps, done at cycle 6; rst mid-CALC -> all outputs 0.

Source files
------------

// File: rtl/rv_mul_seq_pkg.sv
// ============================================================================
// Module   : rv_mul_seq_pkg
// Desc     : funct3 codes, sequencer states and mode decode for rv_mul_seq
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mul_seq_pkg;

  localparam logic [2:0] MUL_MUL    = 3'b000;
  localparam logic [2:0] MUL_MULH   = 3'b001;
  localparam logic [2:0] MUL_MULHSU = 3'b010;
  localparam logic [2:0] MUL_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_CALC = 2'd1,
    SEQ_FIX  = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic hi;
    logic a_signed;
    logic b_signed;
  } mul_mode_t;

  // Unlisted funct3 codes fall back to plain MUL.
  function automatic mul_mode_t decode_mode(input logic [2:0] f);
    mul_mode_t m;
    m = '0;
    case (f)
      MUL_MULH:   m = '{hi: 1'b1, a_signed: 1'b1, b_signed: 1'b1};
      MUL_MULHSU: m = '{hi: 1'b1, a_signed: 1'b1, b_signed: 1'b0};
      MUL_MULHU:  m = '{hi: 1'b1, a_signed: 1'b0, b_signed: 1'b0};
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_mul_seq_if.sv
// ============================================================================
// Module   : rv_mul_seq_if
// Desc     : request/response bundle between control FSM and multiply unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv_mul_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/rv_mul_pp.sv
// ============================================================================
// Module   : rv_mul_pp
// Desc     : DIGITxDIGIT unsigned partial product placed at digit offset k
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mul_pp #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 8,
  parameter int KW    = 3
) (
  input  wire logic [DIGIT-1:0]  a_dig,
  input  wire logic [DIGIT-1:0]  b_dig,
  input  wire logic [KW-1:0]     k,
  output logic      [2*XLEN-1:0] pp
);

  logic [2*DIGIT-1:0] w_prod;

  assign w_prod = {{DIGIT{1'b0}}, a_dig} * {{DIGIT{1'b0}}, b_dig};
  assign pp     = (2*XLEN)'(w_prod) << (k * DIGIT);

endmodule

`default_nettype wire

// File: rtl/rv_mul_seq.sv
// ============================================================================
// Module   : rv_mul_seq
// Desc     : digit-serial RV32M multiply unit (MUL/MULH/MULHSU/MULHU)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mul_seq
  import rv_mul_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DIGIT = 8
) (
  input wire logic    clk,
  input wire logic    rst,
  rv_mul_seq_if.slave bus
);

  localparam int ND = XLEN / DIGIT;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int KW = CW + 1;
  localparam logic [CW-1:0] C_LAST = CW'(ND - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [XLEN-1:0]   r_a_mag;
  logic [XLEN-1:0]   r_b_mag;
  logic              r_neg;
  logic              r_hi;
  logic [CW-1:0]     r_i;
  logic [CW-1:0]     r_j;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  mul_mode_t         w_mode;
  logic              w_accept;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [CW-1:0]     w_j_max;
  logic              w_last;
  logic [KW-1:0]     w_k;
  logic [DIGIT-1:0]  w_a_dig;
  logic [DIGIT-1:0]  w_b_dig;
  logic [2*XLEN-1:0] w_pp;
  logic [2*XLEN-1:0] w_fixed;

  assign w_mode   = decode_mode(bus.funct3);
  assign w_accept = (r_state == SEQ_IDLE) && bus.start && !bus.flush;
  assign w_a_neg  = w_mode.a_signed & bus.op_a[XLEN-1];
  assign w_b_neg  = w_mode.b_signed & bus.op_b[XLEN-1];

  // Low-word mode skips pairs with i+j >= ND: they only touch the discarded half.
  assign w_j_max = r_hi ? C_LAST : (C_LAST - r_i);
  assign w_last  = (r_i == C_LAST) && (r_j == w_j_max);
  assign w_k     = {1'b0, r_i} + {1'b0, r_j};
  assign w_a_dig = r_a_mag[r_i*DIGIT +: DIGIT];
  assign w_b_dig = r_b_mag[r_j*DIGIT +: DIGIT];
  assign w_fixed = r_neg ? -r_acc : r_acc;

  rv_mul_pp #(
    .XLEN  (XLEN),
    .DIGIT (DIGIT),
    .KW    (KW)
  ) u_pp (
    .a_dig (w_a_dig),
    .b_dig (w_b_dig),
    .k     (w_k),
    .pp    (w_pp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEQ_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEQ_IDLE: if (w_accept) w_state_nxt = SEQ_CALC;
      SEQ_CALC: begin
        if (bus.flush)   w_state_nxt = SEQ_IDLE;
        else if (w_last) w_state_nxt = SEQ_FIX;
      end
      SEQ_FIX:  w_state_nxt = bus.flush ? SEQ_IDLE : SEQ_DONE;
      SEQ_DONE: w_state_nxt = SEQ_IDLE;
      default:  w_state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (w_accept) begin
            r_a_mag <= w_a_neg ? -bus.op_a : bus.op_a;
            r_b_mag <= w_b_neg ? -bus.op_b : bus.op_b;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_hi    <= w_mode.hi;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
          end
        end
        SEQ_CALC: begin
          if (!bus.flush) begin
            r_acc <= r_acc + w_pp;
            if (!w_last) begin
              if (r_j == w_j_max) begin
                r_i <= r_i + CW'(1);
                r_j <= '0;
              end else begin
                r_j <= r_j + CW'(1);
              end
            end
          end
        end
        SEQ_FIX: begin
          // Result is loaded here so it is already valid while done is high.
          if (!bus.flush) begin
            r_acc    <= w_fixed;
            r_result <= r_hi ? w_fixed[2*XLEN-1:XLEN] : w_fixed[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != SEQ_IDLE);
  assign bus.done   = (r_state == SEQ_DONE);
  assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_rv_mul_seq.sv
// ============================================================================
// Module   : tb_rv_mul_seq
// Desc     : scoreboard bench for rv_mul_seq at DIGIT=8 and DIGIT=16
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_mul_seq;
  import rv_mul_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst16;

  always #5 clk = ~clk;

  rv_mul_seq_if #(.XLEN(32)) bus ();
  rv_mul_seq_if #(.XLEN(32)) bus16 ();

  rv_mul_seq #(.XLEN(32), .DIGIT(8))  dut   (.clk(clk), .rst(rst),   .bus(bus));
  rv_mul_seq #(.XLEN(32), .DIGIT(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));

  typedef struct packed {
    logic [31:0] res;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_res;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
    bx = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return (f == 3'b001 || f == 3'b010 || f == 3'b011) ? p[63:32] : p[31:0];
  endfunction

  function automatic int lat_of(input logic [2:0] f, input int digit);
    int nd;
    nd = 32 / digit;
    if (f == 3'b001 || f == 3'b010 || f == 3'b011) return nd * nd + 2;
    return nd * (nd + 1) / 2 + 2;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus16.done : bus.done;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? bus16.busy : bus.busy;
  endfunction
  function automatic logic [31:0] get_result(input bit sel);
    return sel ? bus16.result : bus.result;
  endfunction

  // Drive one start cycle; returns #1 after the accept edge (cycle 1).
  task automatic issue_op(input bit sel, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit push);
    exp_t e;
    if (sel) begin
      bus16.start = 1'b1; bus16.funct3 = f; bus16.op_a = a; bus16.op_b = b;
    end else begin
      bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
    end
    if (push) begin
      e.res = exp_res;
      e.lat = 8'(lat_of(f, sel ? 16 : 8));
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (sel) bus16.start = 1'b0; else bus.start = 1'b0;
  endtask

  task automatic collect(input bit sel, input string name);
    int   cyc;
    exp_t e;
    cyc = 1;
    while (get_done(sel) !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s: scoreboard empty at done", name);
      return;
    end
    e = sb.pop_front();
    if (!sel) last_res = e.res;
    if (get_done(sel) !== 1'b1) begin
      n_fail++; $display("FAIL %s: done never seen within %0d cycles", name, cyc);
    end else begin
      n_tests++;
      if (get_result(sel) !== e.res) begin
        n_fail++; $display("FAIL %s result: got %h expected %h", name, get_result(sel), e.res);
      end
      n_tests++;
      if (cyc != int'(e.lat)) begin
        n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, e.lat);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
      n_fail++; $display("FAIL %s post-done: done=%b busy=%b expected 0/0", name, get_done(sel), get_busy(sel));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst16 = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rst16 = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, bus.result} !== 34'b0) begin
      n_fail++; $display("FAIL reset: busy=%b done=%b result=%h expected all 0", bus.busy, bus.done, bus.result);
    end
    n_tests++;
    if ({bus16.busy, bus16.done, bus16.result} !== 34'b0) begin
      n_fail++; $display("FAIL reset16: busy=%b done=%b result=%h expected all 0", bus16.busy, bus16.done, bus16.result);
    end
  endtask

  task automatic test_mul_timing();
    exp_t e;
    issue_op(0, MUL_MUL, 32'd7, 32'd6, 32'h0000_002A, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      n_tests++;
      if (bus.busy !== 1'b1 || bus.done !== (c == 12)) begin
        n_fail++; $display("FAIL mul_timing cycle %0d: busy=%b done=%b expected 1/%b", c, bus.busy, bus.done, c == 12);
      end
      if (c < 12) begin @(posedge clk); #1; end
    end
    e = sb.pop_front();
    last_res = e.res;
    n_tests++;
    if (bus.result !== e.res) begin
      n_fail++; $display("FAIL mul_7x6: got %h expected %h", bus.result, e.res);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mul_idle: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_vectors();
    logic [2:0]  f;
    logic [31:0] a, b;
    issue_op(0, MUL_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1); collect(0, "mul_ff");
    issue_op(0, MUL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); collect(0, "mulhu_ff");
    issue_op(0, MUL_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1); collect(0, "mulh_min");
    issue_op(0, MUL_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1); collect(0, "mulh_neg");
    issue_op(0, MUL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); collect(0, "mulhsu_ff");
    issue_op(0, MUL_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1); collect(0, "mulhu_2_32");
    issue_op(0, 3'b110,     32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b1); collect(0, "funct_other");
    for (int k = 0; k < 8; k++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      issue_op(0, f, a, b, model(f, a, b), 1'b1);
      collect(0, "random");
    end
  endtask

  task automatic test_flush();
    logic [31:0] held;
    int          seen;
    held = last_res;
    issue_op(0, MUL_MULH, 32'h7654_3210, 32'h89AB_CDEF, 32'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      bus.start = c[0];
      bus.op_a  = $urandom;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== held) begin
      n_fail++; $display("FAIL flush: busy=%b done=%b result=%h expected 0/0/%h", bus.busy, bus.done, bus.result, held);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL flush_quiet: activity cycles %0d expected 0", seen);
    end
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = MUL_MUL;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_start_idle: busy=%b expected 0", bus.busy);
    end
    issue_op(0, MUL_MUL, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
    collect(0, "mul_3x5");
  endtask

  task automatic test_back_to_back();
    int   cyc;
    exp_t e;
    issue_op(0, MUL_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, model(MUL_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D), 1'b1);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    e = sb.pop_front();
    n_tests++;
    if (bus.done !== 1'b1 || bus.result !== e.res || cyc != int'(e.lat)) begin
      n_fail++; $display("FAIL b2b_first: result=%h cyc=%0d expected %h/%0d", bus.result, cyc, e.res, e.lat);
    end
    // start raised during DONE must only be taken in the following IDLE cycle
    bus.start = 1'b1; bus.funct3 = MUL_MUL; bus.op_a = 32'h1234_5678; bus.op_b = 32'h0000_0009;
    e.res = model(MUL_MUL, 32'h1234_5678, 32'h0000_0009);
    e.lat = 8'd12;
    sb.push_back(e);
    @(posedge clk); #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    collect(0, "b2b_second");
  endtask

  task automatic test_digit16();
    issue_op(1, MUL_MUL,  32'h0001_0003, 32'h0002_0005, model(MUL_MUL, 32'h0001_0003, 32'h0002_0005), 1'b1);
    collect(1, "d16_mul");
    issue_op(1, MUL_MULH, 32'hF000_0001, 32'h7000_0003, model(MUL_MULH, 32'hF000_0001, 32'h7000_0003), 1'b1);
    collect(1, "d16_mulh");
    issue_op(1, MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    n_tests++;
    if ({bus16.busy, bus16.done, bus16.result} !== 34'b0) begin
      n_fail++; $display("FAIL d16_rst: busy=%b done=%b result=%h expected all 0", bus16.busy, bus16.done, bus16.result);
    end
    issue_op(1, MUL_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, model(MUL_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF), 1'b1);
    collect(1, "d16_mulhsu");
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b0; bus.op_a = '0; bus.op_b = '0;
    bus16.start = 1'b0; bus16.flush = 1'b0; bus16.funct3 = 3'b0; bus16.op_a = '0; bus16.op_b = '0;
    last_res = '0;
    test_reset();
    test_mul_timing();
    test_vectors();
    test_flush();
    test_back_to_back();
    test_digit16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
